square_plot_arbiter: RTL
========================

# square_plot_arbiter

Sequencer and two-way arbiter for the VGA square plotter. It accepts "draw a SIZE×SIZE square at (x, y) in colour c" requests from two independent requesters, such as a moving-object drawer and an eraser. Requests are granted round-robin, and the block emits one pixel per cycle on the x/y/colour/plot port that feeds the VGA adapter. Only one square is drawn at a time, so the pixel port is shared with no interleaving.

## Interface
Parameters:
- SIZE, 4, square side in pixels; power of two, 2..16.

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- resetN  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has a square to draw
- req0_x  in  8  requester 0 top-left x
- req0_y  in  7  requester 0 top-left y
- req0_colour  in  3  requester 0 colour
- req0_ready  out  1  requester 0 accepted this cycle (valid & ready = handshake)
- req1_valid, req1_x, req1_y, req1_colour, req1_ready: same as requester 0, for requester 1
- x_out  out  8  pixel x
- y_out  out  7  pixel y
- colour_out  out  3  pixel colour
- plot  out  1  x_out/y_out/colour_out are a pixel write this cycle
- busy  out  1  a square is being drawn (DRAW or DONE state)
- done  out  1  one-cycle pulse after the last pixel of a square

## Operation
- States:
  - IDLE: ready may be asserted.
  - DRAW: pixels are emitted.
  - DONE: done=1, plot=0.
- Transitions:
  - IDLE→DRAW on any handshake.
  - DRAW→DONE after the last pixel.
  - DONE→IDLE unconditionally.
- Arbitration is combinational in IDLE only. last_grant is a 1-bit register, reset to 1, so requester 0 wins the first conflict.
  - Only req0_valid: req0_ready=1.
  - Only req1_valid: req1_ready=1.
  - Both valid: the requester ≠ last_grant gets ready.
  - At most one ready is high in any cycle.
  - Both readys are 0 outside IDLE.
- On handshake:
  - base_x, base_y and colour latch from the granted requester.
  - last_grant ← granted index.
  - ix, iy ← 0.
- DRAW, raster order:
  - Emit pixel (base_x+ix, base_y+iy).
  - ix increments every cycle. When ix wraps at SIZE-1, iy increments.
  - The pixel with ix=iy=SIZE-1 is the last one.
- Arithmetic:
  - x_out = base_x + ix, truncated to 8 bits (wraps mod 256).
  - y_out = base_y + iy, truncated to 7 bits (wraps mod 128).
  - No clipping. Off-screen coordinates are emitted as-is.
- colour_out holds the latched colour. Colour 0 is plotted like any other colour (erase).
- A requester may drop valid before ready without penalty. Requests are not queued; held inputs are sampled only at the handshake.
- Input changes after the handshake do not affect the square in progress.
- Reset:
  - Values: state=IDLE, base_x=0, base_y=0, colour=0, ix=iy=0, last_grant=1.
  - Outputs: x_out=0, y_out=0, colour_out=0, plot=0, busy=0, done=0, both ready=0 (absent valid).
  - Reset mid-DRAW aborts the square immediately. No further plot and no done pulse.

## Timing
- Handshake in cycle T:
  - First pixel (plot=1) in T+1.
  - Last pixel in T+SIZE².
  - done=1 in T+SIZE²+1.
  - IDLE again in T+SIZE²+2; a new handshake is possible in that same cycle.
- Throughput: one square per SIZE²+2 cycles (18 for SIZE=4).
- plot, busy and done are decoded from registered state. x_out/y_out/colour_out are combinational from registers only. No input-to-output combinational path except valid→ready.
- A valid arriving during DRAW/DONE waits. It is arbitrated on the first IDLE cycle against whatever is then valid.

## Structure
- Shared package square_plot_pkg:
  - X_W=8, Y_W=7, C_W=3.
  - State encodings ST_IDLE, ST_DRAW, ST_DONE.
  - Reused by the VGA top and other drawers.
- Sub-module rr_arbiter2: two-input round-robin grant with a last_grant register and an update-on-accept input. Instantiated once here; reusable elsewhere.
- Counters ix/iy are $clog2(SIZE) bits wide and inline in the top.

## Test plan
- Reset, then req0 (x=10, y=20, c=3) alone: ready0 in the first IDLE cycle. 16 plot cycles cover x 10..13 × y 20..23 in raster order with colour 3. done pulses once; busy is 1 for 17 cycles.
- Both valid continuously with distinct squares: grants alternate 0,1,0,1. Each square completes before the next starts, and readys are never both high.
- Wrap: req1 (x=254, y=126, c=5): x_out sequence 254,255,0,1 and y_out 126,127,0,1. No extra cycles.
- Inputs changed during DRAW, and a valid dropped before grant: the in-progress square keeps its latched values, and the dropped request is never drawn.
- resetN low at the 5th pixel: from the next edge plot=0, busy=0, no done, outputs 0. A fresh request after release draws a full 16 pixels, with requester 0 given priority.

Source files
------------

// File: rtl/square_plot_pkg.sv
// Shared widths, FSM encodings and request record for the VGA square drawers.
// Imported by the plotter arbiter, the VGA top and any other pixel producers.
package square_plot_pkg;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic [C_W-1:0] colour;
   } sq_req_t;

endpackage

// File: rtl/square_plot_arbiter_rr.sv
// Two-input round-robin grant, combinational from req when enabled; the
// last_grant pointer only moves on an accepted grant, so a dropped request costs nothing.
module rr_arbiter2 (
   input  logic       clock,
   input  logic       resetN,
   input  logic       en_i,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);

   logic last_grant_q;
   logic last_grant_d;

   // On a conflict the requester that did not win last time gets the grant.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (accept_i && (gnt_o != 2'b00)) begin
         last_grant_d = gnt_o[1];
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/square_plot_arbiter.sv
// Arbitrates two square-draw requesters and rasterises one SIZE x SIZE square at a time,
// one pixel per cycle; handshake only in IDLE, so a square takes SIZE*SIZE+2 cycles.
module square_plot_arbiter
   import square_plot_pkg::*;
#(
   parameter int SIZE = 4
) (
   input  logic           clock,
   input  logic           resetN,
   input  logic           req0_valid,
   input  logic [X_W-1:0] req0_x,
   input  logic [Y_W-1:0] req0_y,
   input  logic [C_W-1:0] req0_colour,
   output logic           req0_ready,
   input  logic           req1_valid,
   input  logic [X_W-1:0] req1_x,
   input  logic [Y_W-1:0] req1_y,
   input  logic [C_W-1:0] req1_colour,
   output logic           req1_ready,
   output logic [X_W-1:0] x_out,
   output logic [Y_W-1:0] y_out,
   output logic [C_W-1:0] colour_out,
   output logic           plot,
   output logic           busy,
   output logic           done
);

   localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [CW-1:0] IMAX = CW'(SIZE - 1);

   state_t        state_q;
   state_t        state_d;
   sq_req_t       sq_q;
   sq_req_t       sq_d;
   logic [CW-1:0] ix_q;
   logic [CW-1:0] ix_d;
   logic [CW-1:0] iy_q;
   logic [CW-1:0] iy_d;
   logic [1:0]    gnt;
   logic          hs;
   logic          last_px;
   sq_req_t       req0;
   sq_req_t       req1;

   assign req0 = '{x: req0_x, y: req0_y, colour: req0_colour};
   assign req1 = '{x: req1_x, y: req1_y, colour: req1_colour};

   rr_arbiter2 u_arb (
      .clock    (clock),
      .resetN   (resetN),
      .en_i     (state_q == ST_IDLE),
      .req_i    ({req1_valid, req0_valid}),
      .accept_i (hs),
      .gnt_o    (gnt)
   );

   assign hs         = |gnt;
   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];
   assign last_px    = (ix_q == IMAX) && (iy_q == IMAX);

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (hs) state_d = ST_DRAW;
         ST_DRAW: if (last_px) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      plot = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_DRAW: begin
            plot = 1'b1;
            busy = 1'b1;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Request fields are captured only at the handshake; later input changes are ignored.
   always_comb begin
      sq_d = sq_q;
      ix_d = ix_q;
      iy_d = iy_q;
      if ((state_q == ST_IDLE) && hs) begin
         sq_d = gnt[1] ? req1 : req0;
         ix_d = '0;
         iy_d = '0;
      end else if (state_q == ST_DRAW) begin
         ix_d = ix_q + CW'(1);
         if (ix_q == IMAX) begin
            iy_d = iy_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         sq_q <= '0;
         ix_q <= '0;
         iy_q <= '0;
      end else begin
         sq_q <= sq_d;
         ix_q <= ix_d;
         iy_q <= iy_d;
      end
   end

   // Coordinates wrap modulo the port width; no clipping.
   assign x_out      = sq_q.x + X_W'(ix_q);
   assign y_out      = sq_q.y + Y_W'(iy_q);
   assign colour_out = sq_q.colour;

endmodule
